// File: rtl/rshift16_seq_pkg.sv
// Shared definitions for the iterative right shifter.
// Holds the default data/amount widths, the FSM state encoding and a helper
// that sizes the stage counter from the shift-amount width.
package rshift16_seq_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SHW_DEF   = 4;

    typedef logic [1:0] state_t;

    // Encoding 2'd3 is unused and steers back to ST_IDLE.
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    // Counter width needed to index SHW stages (at least one bit).
    function automatic int cnt_width(input int shw);
        return (shw > 1) ? $clog2(shw) : 1;
    endfunction

endpackage

// File: rtl/rshift16_seq_stage.sv
// One combinational rank of the right shifter.
// Ports:
//   d    - data into the rank
//   k    - stage index; this rank shifts by 2^k
//   en   - 1 = apply the shift, 0 = pass d through
//   fill - value written into the vacated upper bits
//   q    - rank output
module rshift_stage
    import rshift16_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF,
    parameter int CW    = cnt_width(SHW_DEF)
) (
    input  logic [WIDTH-1:0] d,
    input  logic [CW-1:0]    k,
    input  logic             en,
    input  logic             fill,
    output logic [WIDTH-1:0] q
);

    localparam logic [SHW-1:0] ONE = 1;

    logic [SHW-1:0]   w_dist;
    logic [WIDTH-1:0] w_mask;

    always_comb begin
        w_dist = ONE << k;
        // Ones in exactly the upper 2^k positions that the shift vacates.
        w_mask = ~({WIDTH{1'b1}} >> w_dist);
        q      = en ? ((d >> w_dist) | (fill ? w_mask : '0)) : d;
    end

endmodule

// File: rtl/rshift16_seq.sv
// Iterative right shifter (logical / arithmetic) behind valid/ready handshakes.
// A single shift rank is reused for SHW cycles, so every operation takes the
// same number of cycles regardless of the shift amount.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   in_valid, in_ready  - operand handshake (A, shr, arith)
//   A, shr, arith       - operand, right-shift amount, 1 = sign fill
//   out_valid, out_ready- result handshake
//   OUT                 - registered result
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for an operand, in_ready=1
// ST_SHIFT | applying stage r_cnt of the shift, one stage per cycle
// ST_DONE  | result on OUT with out_valid=1 until out_ready
module rshift16_seq
    import rshift16_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   shr,
    input  logic             arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] OUT
);

    localparam int            CW       = cnt_width(SHW);
    localparam logic [CW-1:0] CNT_LAST = CW'(SHW - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_amt;
    logic             r_fill;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_out;

    logic [WIDTH-1:0] w_step;

    rshift_stage #(
        .WIDTH (WIDTH),
        .SHW   (SHW),
        .CW    (CW)
    ) u_stage (
        .d    (r_data),
        .k    (r_cnt),
        .en   (r_amt[r_cnt]),
        .fill (r_fill),
        .q    (w_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_amt   <= '0;
            r_fill  <= 1'b0;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data  <= A;
                        r_amt   <= shr;
                        // Sign captured once so every stage fills with the original MSB.
                        r_fill  <= arith & A[WIDTH-1];
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_data <= w_step;
                    r_cnt  <= r_cnt + CNT_ONE;
                    if (r_cnt == CNT_LAST) begin
                        // OUT only ever changes here, so it never shows a partial shift.
                        r_out   <= w_step;
                        r_cnt   <= '0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign OUT       = r_out;

endmodule

// File: doc/rshift16_seq.md
Name: rshift16_seq

Overview:
Iterative 16-bit right shifter: the right-direction counterpart of the team's combinational left barrel shifter. Supports logical and arithmetic modes. It shares one log-stage datapath over SHW cycles instead of instantiating SHW mux ranks. Sits in the ALU shift path behind a valid/ready handshake, for area-constrained builds where a multi-cycle shift is acceptable.

Parameters:
WIDTH, 16, data width in bits; must be a power of two.
SHW, 4, shift-amount width; equals log2(WIDTH).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous active-high reset.
in_valid  in  1  A/shr/arith are valid this cycle.
in_ready  out  1  block can accept an operand this cycle.
A  in  WIDTH  operand.
shr  in  SHW  right-shift amount, 0..WIDTH-1.
arith  in  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
out_valid  out  1  OUT holds a completed result.
out_ready  in  1  consumer accepts OUT this cycle.
OUT  out  WIDTH  shifted result.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, OUT=0, internal data/amount/fill regs=0, stage counter=0.
- States:
  - IDLE: in_ready=1. On in_valid, register A into data, shr into amt, and fill = arith & A[WIDTH-1]. Clear cnt to 0 and go to SHIFT.
  - SHIFT: in_ready=0. Each cycle: if amt[cnt], data <= data >> 2^cnt, with the vacated upper 2^cnt bits set to fill; otherwise data is held. cnt increments each cycle. When cnt == SHW-1, perform the last step and go to DONE.
  - DONE: out_valid=1 and OUT=data. If out_ready, go to IDLE (out_valid drops next cycle). Otherwise hold OUT stable.
- Latency is fixed and independent of shr:
  - input accepted at edge 0;
  - out_valid first asserted after edge SHW (4 cycles for the default).
  - shr=0 still takes SHW cycles and returns A unchanged.
- Throughput: at most one operation per SHW+2 cycles. There is no input acceptance in SHIFT or DONE; in_ready is a pure function of state.
- Backpressure: OUT and out_valid are held indefinitely in DONE while out_ready=0.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored; the operand is not queued.
- Fill rule: the fill bit is captured once at accept, so all stages use the original sign. arith=1 with A[WIDTH-1]=0 behaves as logical.
- Reset mid-operation, in SHIFT or DONE:
  - the operation is aborted;
  - the next cycle shows the reset values;
  - no partial result is ever presented.
- Reset has priority over every handshake in the same cycle.
- OUT is driven from a register, with no combinational path from inputs to outputs.

Decomposition:
- Shared package: WIDTH/SHW defaults; state encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2 (2'd3 is illegal and recovers to IDLE).
- Sub-module rshift_stage (combinational, one rank):
  - inputs d[WIDTH-1:0], k (stage index), en, fill;
  - output q = en ? {fill x 2^k, d[WIDTH-1:2^k]} : d.
- The top level holds the FSM, counter and registers, and reuses one rshift_stage instance driven by cnt.

Test Plan:
- A=0x1234, shr=0, arith=0, out_ready=1 -> OUT=0x1234; out_valid rises exactly 4 cycles after accept and lasts 1 cycle.
- A=0x8000, shr=15, arith=0 -> OUT=0x0001. Same operand with arith=1 -> OUT=0xFFFF.
- A=0x8000, shr=4, arith=1 -> 0xF800. A=0x7F00, shr=4, arith=1 -> 0x07F0 (positive operand, zero fill).
- Backpressure: A=0xABCD, shr=8, arith=0, out_ready=0 for 10 cycles -> OUT=0x00AB and out_valid=1 held stable throughout. in_valid pulses in that window are ignored; accept resumes one cycle after out_ready=1.
- Reset asserted 2 cycles after accept -> next cycle: state IDLE, in_ready=1, out_valid=0, OUT=0. A new operand 0x00F0, shr=4 then yields 0x000F.
- Random sweep: 1000 operands, all shr and both modes, with random out_ready -> every result matches the reference model (logical >>, or signed >>>).
